// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one unified memory between fetch and data requesters,
//            inserting WAIT_CYCLES strobe cycles per access. Optional macro
//            MEM_ARB_ROUND_ROBIN_EN swaps fixed data priority for alternation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1) begin : g_wait_check
      $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_dm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                w_any_req;
  logic                w_grant_dm;
  logic                w_cnt_zero;
  logic                w_is_write;

  assign w_any_req  = if_req | dm_req;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_is_write = r_owner_dm & r_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Tie goes to whoever was not served last; a lone request always wins.
  logic r_last_dm;

  assign w_grant_dm = dm_req & (~if_req | ~r_last_dm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dm <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_dm <= w_grant_dm;
    end
  end
`else
  // The data access belongs to the instruction already in flight, so it wins.
  assign w_grant_dm = dm_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner_dm <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_dm <= w_grant_dm;
            r_we       <= w_grant_dm & dm_we;
            r_addr     <= w_grant_dm ? dm_addr : if_addr;
            r_wdata    <= w_grant_dm ? dm_wdata : '0;
            r_cnt      <= c_CNT_LOAD;
          end
        end
        S_ACCESS: begin
          if (w_cnt_zero) begin
            if (!r_owner_dm) begin
              r_if_rdata <= mem_rdata;
            end else if (!r_we) begin
              r_dm_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if_done     = 1'b0;
    dm_done     = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy      = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_read  = ~w_is_write;
        mem_write = w_is_write;
        if (w_cnt_zero) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        if_done     = ~r_owner_dm;
        dm_done     = r_owner_dm;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Random fetch/data requesters against a transaction-level reference model;
// expected accesses are queued at grant time and checked by a separate monitor.
module tb_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int W  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_done, dm_req, dm_we, dm_done;
  logic          mem_read, mem_write, busy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 37 + (a >> 8) * 11 + 5);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] base;
    base = ($urandom_range(0, 1) == 1) ? 13'h1F00 : 13'h0010;
    return base + AW'($urandom_range(0, 7));
  endfunction

  // Memory environment driven purely by the DUT's pins.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic [DW-1:0] garb;
  assign mem_rdata = mem_read ? env_mem[mem_addr] : garb;

  initial begin
    for (int i = 0; i < (1 << AW); i++) env_mem[i] = init_val(i);
    garb = 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_write) env_mem[mem_addr] <= mem_wdata;
      garb <= DW'($urandom);
    end
  end

  // Reference model: one access at a time, W strobe cycles, done one cycle later.
  typedef struct {
    bit            dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            start;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cyc = 0;
  int            free_at = 0;
  bit            last_dm = 1'b0;

  initial begin
    bit   gdm;
    exp_t e;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        free_at = cyc + 1;
        last_dm = 1'b0;
      end else if (cyc >= free_at && (if_req || dm_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gdm = dm_req && (!if_req || !last_dm);
`else
        gdm = dm_req;
`endif
        e.dm    = gdm;
        e.we    = gdm && dm_we;
        e.addr  = gdm ? dm_addr : if_addr;
        e.wdata = gdm ? dm_wdata : '0;
        e.start = cyc + 1;
        if (e.we) begin
          ref_mem[e.addr] = e.wdata;
          e.rdata = '0;
        end else begin
          e.rdata = ref_mem[e.addr];
        end
        q.push_back(e);
        free_at = cyc + W + 2;
        last_dm = gdm;
      end
      cyc++;
    end
  end

  // Requesters: hold req until done, drop it for at least one cycle afterwards.
  bit if_en, dm_en, if_cool, dm_cool;

  initial begin
    if_req = 1'b1; if_addr = rnd_addr(); if_cool = 1'b0;
    forever begin
      @(negedge clk);
      if (if_req) begin
        if (if_done) begin
          if_req = 1'b0; if_cool = 1'b1; if_addr = rnd_addr();
        end else if ($urandom_range(0, 3) == 0) begin
          if_addr = rnd_addr();
        end
      end else if (if_cool) begin
        if_cool = 1'b0;
      end else if (if_en && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
    end
  end

  initial begin
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = rnd_addr(); dm_wdata = 8'h3C; dm_cool = 1'b0;
    forever begin
      @(negedge clk);
      if (dm_req) begin
        if (dm_done) begin
          dm_req = 1'b0; dm_cool = 1'b1;
        end
        if (dm_done || $urandom_range(0, 3) == 0) begin
          dm_addr = rnd_addr(); dm_we = 1'($urandom); dm_wdata = DW'($urandom);
        end
      end else if (dm_cool) begin
        dm_cool = 1'b0;
      end else if (dm_en && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_addr = rnd_addr(); dm_we = 1'($urandom); dm_wdata = DW'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rd_idx = 0;
  logic [DW-1:0] exp_if = '0;
  logic [DW-1:0] exp_dm = '0;
  bit            stop_req, tmo;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    bit   wr;
    forever begin
      @(negedge clk);
      #2;
      if (stop_req) begin
        chk("timeout", 32'(tmo), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (!rst_n) begin
        rd_idx = q.size();
        exp_if = '0;
        exp_dm = '0;
        chk("reset_ctl", 32'({if_done, dm_done, mem_read, mem_write, busy}), 32'd0);
        chk("reset_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        chk("reset_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
      end else begin
        if (rd_idx < q.size() && cyc >= q[rd_idx].start && cyc < q[rd_idx].start + W) begin
          e  = q[rd_idx];
          wr = e.dm && e.we;
          chk("access_ctl", 32'({if_done, dm_done, mem_read, mem_write, busy}),
              32'({2'b00, !wr, wr, 1'b1}));
          chk("access_addr", 32'(mem_addr), 32'(e.addr));
          chk("access_wdata", 32'(mem_wdata), 32'(e.wdata));
        end else if (rd_idx < q.size() && cyc == q[rd_idx].start + W) begin
          e = q[rd_idx];
          chk("done_ctl", 32'({if_done, dm_done, mem_read, mem_write, busy}),
              32'({!e.dm, e.dm, 3'b001}));
          chk("done_bus", 32'({mem_addr, mem_wdata}), 32'd0);
          if (!e.dm) exp_if = e.rdata;
          else if (!e.we) exp_dm = e.rdata;
          rd_idx++;
        end else begin
          chk("idle_ctl", 32'({if_done, dm_done, mem_read, mem_write, busy}), 32'd0);
          chk("idle_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        end
        chk("if_rdata", 32'(if_rdata), 32'(exp_if));
        chk("dm_rdata", 32'(dm_rdata), 32'(exp_dm));
      end
    end
  end

  // Sequence: reset with both reqs high, random traffic, reset mid-fetch, more traffic.
  initial begin
    bit found;
    rst_n = 1'b0; if_en = 1'b1; dm_en = 1'b1; tmo = 1'b0; stop_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);

    dm_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (rd_idx < q.size() && !q[rd_idx].dm && cyc == q[rd_idx].start + 1) begin
        rst_n = 1'b0;
        found = 1'b1;
      end
    end
    if (!found) tmo = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dm_en = 1'b1;

    repeat (1200) @(negedge clk);
    stop_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL watchdog: monitor never reached summary");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the fetch requester (IF state, address from PC) and the data requester (LDI/STR-type states, address from TR).
- Owns the memory control pins (address, write data, read, write) and inserts a configurable number of wait cycles per access.
- Returns read data and a one-cycle done pulse to whichever requester was served.
- Sits between the multicycle controller/datapath and the memory model, replacing the direct sel_MEM_src_PC / sel_MEM_src_TR / MEM_read / MEM_write drive.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 8, memory data width
WAIT_CYCLES, 1, cycles mem_read/mem_write are held per access; legal range >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched word
dm_req  in  1  data request; held high until dm_done
dm_we  in  1  1 = write, 0 = read; sampled with dm_req
dm_addr  in  ADDR_W  data address (TR)
dm_wdata  in  DATA_W  write data
dm_done  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  data read result
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data, valid while mem_read is high
busy  out  1  high in ACCESS and DONE states

Behaviour:
- Reset (rst=0, async): state=IDLE; every output = 0; owner = data; wait counter = 0; last_owner = fetch.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Neither req high: stay in IDLE.
  - Any req high: arbitrate, then register owner, address, we and wdata from the winner; load counter = WAIT_CYCLES-1; go to ACCESS.
- Arbitration (fixed): dm_req beats if_req. Data belongs to the instruction already in flight.
- ACCESS:
  - mem_addr and mem_wdata are driven from the registered copies and held stable for the whole state.
  - mem_read = 1 unless owner = data and we = 1.
  - mem_write = owner = data and we = 1. Fetch never writes.
  - Counter decrements each cycle. In the cycle the counter = 0, mem_rdata is captured into the owner's rdata register, then the FSM goes to DONE.
- DONE:
  - Owner's done = 1 for exactly one cycle. mem_read = mem_write = 0.
  - rdata register holds its value until the next access by the same owner.
  - Writes leave dm_rdata unchanged.
  - Next state: IDLE.
- Latency: req seen high in IDLE cycle t → ACCESS cycles t+1 .. t+WAIT_CYCLES → done at t+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Requester rule: req must be low in the cycle after its done pulse. A req still high in that IDLE cycle is a new request.
- Requests arriving during ACCESS or DONE are not sampled. They wait for IDLE.
- Inputs are sampled only in IDLE. Changes to addr/we/wdata during ACCESS have no effect.
- Reset mid-access: mem_read/mem_write drop immediately (async); no done pulse is issued; the FSM restarts in IDLE.
- mem_addr/mem_wdata return to 0 in IDLE and DONE.
- WAIT_CYCLES = 0 is illegal: elaboration-time assertion error.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both reqs are high in IDLE, grant the requester that is not last_owner.
  - last_owner updates on every grant.
  - A single pending req is granted regardless.
  - First tie after reset goes to data.
- Undefined: fixed data-over-fetch priority; no last_owner register.

Test Plan:
1. Reset: hold rst=0 with both reqs high → all outputs 0, busy=0. Release rst → first access starts on the next IDLE sample.
2. Fetch, WAIT_CYCLES=1: if_req=1, if_addr=0x0010, mem_rdata=0xA5 at cycle 0 → mem_read=1 and mem_addr=0x0010 in cycle 1; if_done=1 and if_rdata=0xA5 in cycle 2; mem_write never 1.
3. Data write, WAIT_CYCLES=3: dm_req=1, dm_we=1, dm_addr=0x1F00, dm_wdata=0x3C; change dm_addr in cycle 2 → mem_write=1, mem_addr=0x1F00, mem_wdata=0x3C held in cycles 1-3; dm_done in cycle 4; mem_read=0 throughout.
4. Tie, WAIT_CYCLES=1, fixed priority: if_req=dm_req=1 at cycle 0 → dm_done in cycle 2, ACCESS for fetch in cycle 4, if_done in cycle 5. Check if_rdata and dm_rdata each hold their own word.
5. Reset mid-access, WAIT_CYCLES=4: assert rst=0 in the 2nd ACCESS cycle → mem_read falls in that same cycle; no if_done/dm_done ever pulses for that access; state=IDLE after release.
6. MEM_ARB_ROUND_ROBIN_EN: both reqs re-asserted after every done, for 4 grants → order is data, fetch, data, fetch. With the macro undefined, the same stimulus gives data, data, data, data (fetch starved).
